data_ram_p: RTL and testbench
=============================

DATA_RAM_P -- requirements
Module: data_ram_p

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits, multiple of 8, at least 16.
REQ-002 SHALL have parameter DEPTH, default 1024: number of words, power of two, at least 2.
REQ-003 SHALL have parameter ADDR_W, default 32: byte-address width, at least log2(DEPTH)+log2(DATA_W/8).
REQ-004 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port `rst`, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port `req_valid`, input, 1 bit: request present.
REQ-007 SHALL have port `req_ready`, output, 1 bit: block can accept a request.
REQ-008 SHALL have port `req_we`, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port `req_addr`, input, ADDR_W bits: byte address.
REQ-010 SHALL have port `req_sel`, input, DATA_W/8 bits: byte-lane enables, bit i = bits [8i+7:8i].
REQ-011 SHALL have port `req_wdata`, input, DATA_W bits: write data.
REQ-012 SHALL have port `rsp_valid`, output, 1 bit: one-cycle response pulse.
REQ-013 SHALL have port `rsp_rdata`, output, DATA_W bits: read data.
REQ-014 SHALL have port `rsp_err`, output, 1 bit: misaligned-access flag.
REQ-015 SHALL have port `busy`, output, 1 bit: clear sequence in progress.

Function
REQ-016 Storage SHALL be DATA_W/8 byte-wide arrays of DEPTH entries; word index = req_addr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)]; higher address bits ignored (addresses wrap modulo DEPTH words).
REQ-017 FSM states SHALL be INIT and RUN.
REQ-018 INIT SHALL write all-zero to one word per cycle, indices 0 to DEPTH-1, with busy=1 and req_ready=0, then go to RUN after exactly DEPTH cycles.
REQ-019 In RUN, req_ready SHALL be 1 and busy SHALL be 0.
REQ-020 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1, at most one per cycle.
REQ-021 An accepted write SHALL update only the lanes with req_sel[i]=1; req_sel=0 SHALL change nothing and still be accepted.
REQ-022 Every accepted request SHALL produce rsp_valid=1 for exactly the following cycle; the response SHALL NOT be back-pressured.
REQ-023 Read: rsp_rdata in the response cycle SHALL be the full stored word, with all lanes returned regardless of req_sel.
REQ-024 Write: rsp_rdata in the response cycle SHALL be 0.
REQ-025 A read accepted the cycle after a write to the same word SHALL return the newly written bytes.
REQ-026 When rsp_valid=0, rsp_rdata SHALL be 0 and rsp_err SHALL be 0.
REQ-027 req_valid while busy=1 SHALL be ignored, producing no write and no response.

Reset
REQ-028 rst=1 SHALL asynchronously force: FSM=INIT, clear index=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, busy=1.
REQ-029 rst asserted mid-clear or mid-transaction SHALL abandon any pending response; the clear SHALL restart from index 0 after rst falls.

Configuration
REQ-030 With macro DATA_RAM_MISALIGN_CHK_EN defined, a request SHALL be misaligned if any of these holds: (a) req_sel has non-contiguous set bits; (b) the lowest set bit of a non-zero req_sel differs from req_addr[log2(DATA_W/8)-1:0]; (c) a read has req_sel=0.
REQ-031 With DATA_RAM_MISALIGN_CHK_EN defined, a misaligned request SHALL still be accepted, its write SHALL be suppressed, and its response SHALL carry rsp_err=1 and rsp_rdata=0.
REQ-032 Without DATA_RAM_MISALIGN_CHK_EN, the low address bits SHALL be ignored and rsp_err SHALL be tied to 0.

Verification
REQ-033 Bench SHALL cover reset then idle: DEPTH=16 -> busy=1 and req_ready=0 for 16 cycles, then busy=0 and req_ready=1; read of addr 0x3C -> rdata 0x00000000.
REQ-034 Bench SHALL cover byte-lane write: write 0x11223344 sel=1111 to addr 0x8, write 0xAABBCCDD sel=0100 to addr 0x8, read addr 0x8 -> rdata 0x11BB3344 with rsp_valid one cycle after acceptance.
REQ-035 Bench SHALL cover back-to-back traffic: write 0xDEADBEEF to addr 0x4 then read addr 0x4 the next cycle -> rdata 0xDEADBEEF; rsp_valid high for 2 consecutive cycles.
REQ-036 Bench SHALL cover wrap-around: DEPTH=16, write 0x5A5A5A5A to addr 0x40 -> read of addr 0x0 returns 0x5A5A5A5A.
REQ-037 Bench SHALL cover reset mid-operation: rst pulsed during a read and during INIT at index 7 -> no response; clear restarts at 0; data written before the reset reads 0 afterwards.
REQ-038 Bench SHALL cover misalignment with the macro defined: write sel=1111 to addr 0x2 -> rsp_err=1 and memory unchanged; write sel=1100 to addr 0x2 -> rsp_err=0 and write performed; without the macro, the same sel=1111 write writes word 0 with rsp_err=0.

Source files
------------

// File: rtl/data_ram_p.sv
// ============================================================================
//  Module   : data_ram_p
//  Purpose  : Byte-lane RAM with valid/ready requests and single-cycle
//             responses; self-clears to zero after reset. Define
//             DATA_RAM_MISALIGN_CHK_EN to enable misaligned-access detection.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_ram_p #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_sel,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_clr_idx;
    logic [IDX_W-1:0]   w_clr_idx_nxt;
    logic [IDX_W-1:0]   w_word_idx;
    logic [IDX_W-1:0]   w_mem_idx;
    logic               w_accept;
    logic               w_err;
    logic               w_wr_en;
    logic               r_rsp_valid;
    logic               r_rsp_rd;
    logic               r_rsp_err;
    logic               w_unused;

    // ------------------------------------------------------------------
    // Control FSM: INIT sweeps every word to zero, RUN serves requests
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        req_ready     = 1'b0;
        busy          = 1'b0;
        case (r_state)
            ST_INIT: begin
                busy          = 1'b1;
                w_clr_idx_nxt = r_clr_idx + IDX_W'(1);
                if (r_clr_idx == IDX_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign w_accept   = req_valid & req_ready;
    assign w_word_idx = req_addr[OFF_W +: IDX_W];
    assign w_mem_idx  = (r_state == ST_INIT) ? r_clr_idx : w_word_idx;
    assign w_wr_en    = w_accept & req_we & ~w_err;

`ifdef DATA_RAM_MISALIGN_CHK_EN
    int               w_rises;
    logic             w_prev;
    logic             w_found;
    logic [OFF_W-1:0] w_low;

    // Misaligned: lanes not one contiguous run, first lane not at the
    // byte offset, or a read that selects no lanes at all.
    always_comb begin
        w_rises = 0;
        w_prev  = 1'b0;
        w_found = 1'b0;
        w_low   = '0;
        for (int i = 0; i < LANES; i++) begin
            if (req_sel[i] && !w_prev) begin
                w_rises = w_rises + 1;
            end
            if (req_sel[i] && !w_found) begin
                w_low   = OFF_W'(i);
                w_found = 1'b1;
            end
            w_prev = req_sel[i];
        end
        w_err = (w_rises > 1)
              || (w_found && (w_low != req_addr[OFF_W-1:0]))
              || (!req_we && !w_found);
    end
`else
    assign w_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Storage: one byte-wide array per lane; read port is registered
    // ------------------------------------------------------------------
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_rd_byte;
        logic       w_lane_we;
        logic [7:0] w_lane_wd;

        assign w_lane_we = (r_state == ST_INIT) | (w_wr_en & req_sel[g]);
        assign w_lane_wd = (r_state == ST_INIT) ? 8'h00 : req_wdata[8*g +: 8];

        always_ff @(posedge clk) begin
            if (w_lane_we) begin
                r_mem[w_mem_idx] <= w_lane_wd;
            end
            r_rd_byte <= r_mem[w_mem_idx];
        end

        assign rsp_rdata[8*g +: 8] = r_rsp_rd ? r_rd_byte : 8'h00;
    end

    // Response flags carry the async reset so a pending response dies with rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rd    <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_rd    <= w_accept & ~req_we & ~w_err;
            r_rsp_err   <= w_accept & w_err;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;

    // Upper address bits wrap and offset bits matter only with the checker
    assign w_unused = &{1'b0, req_addr};

endmodule

`default_nettype wire

// File: tb/tb_data_ram_p.sv
// ============================================================================
//  Module   : tb_data_ram_p
//  Purpose  : Self-checking bench for data_ram_p (DEPTH=16, 32-bit words).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_ram_p;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;
`ifdef DATA_RAM_MISALIGN_CHK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_sel = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    data_ram_p #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_sel   (req_sel),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] cyc = '0;

    always @(posedge clk) cyc <= cyc + 32'd1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] cyc;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t tbl[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every response
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                check("rsp_cycle", cyc, e.cyc);
            end
        end else begin
            check("idle_rsp", rsp_rdata | {31'b0, rsp_err}, 32'h0);
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        check("req_ready_at_issue", {31'b0, req_ready}, 32'h1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_sel   = sel;
        req_wdata = wd;
        sb.push_back('{exp_rd, exp_err, cyc + 32'd1});
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_sel   = '0;
        req_wdata = '0;
    endtask

    // Called right after rst falls; counts cycles until the clear completes
    task automatic wait_clear(input string name);
        int n;
        n = 0;
        check({name, "_busy_start"}, {31'b0, busy}, 32'h1);
        check({name, "_ready_start"}, {31'b0, req_ready}, 32'h0);
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        check({name, "_clear_cycles"}, n, DEPTH);
        check({name, "_ready_end"}, {31'b0, req_ready}, 32'h1);
        check({name, "_busy_end"}, {31'b0, busy}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // we, addr, sel, wdata, exp_rdata, exp_err
        tbl[0]  = '{1'b0, 32'h3C, 4'hF, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 32'h08, 4'hF, 32'h11223344, 32'h0, 1'b0};
        tbl[2]  = '{1'b1, (MIS ? 32'h0A : 32'h08), 4'b0100, 32'hAABBCCDD, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 32'h08, 4'hF, 32'h0, 32'h11BB3344, 1'b0};
        tbl[4]  = '{1'b1, 32'h04, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0};
        tbl[5]  = '{1'b0, 32'h04, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 32'h40, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, 32'h00, 4'hF, 32'h0, 32'h5A5A5A5A, 1'b0};
        tbl[8]  = '{1'b1, 32'h0C, 4'h0, 32'h12345678, 32'h0, 1'b0};
        tbl[9]  = '{1'b0, 32'h0C, 4'hF, 32'h0, 32'h0, 1'b0};
        tbl[10] = '{1'b1, 32'h3C, 4'hF, 32'h01020304, 32'h0, 1'b0};
        tbl[11] = '{1'b0, 32'h3C, 4'hF, 32'h0, 32'h01020304, 1'b0};
        tbl[12] = '{1'b0, 32'h7C, 4'hF, 32'h0, 32'h01020304, 1'b0};
        tbl[13] = '{1'b1, 32'h10, 4'b0011, 32'hCAFEBABE, 32'h0, 1'b0};
        tbl[14] = '{1'b0, 32'h10, 4'hF, 32'h0, 32'h0000BABE, 1'b0};

        // Reset state and initial clear
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'h1);
        check("rst_ready", {31'b0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        rst = 1'b0;
        wait_clear("init");

        // Table vectors, issued back-to-back
        for (int i = 0; i < 15; i++) begin
            issue(tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err);
        end
        go_idle();
        @(posedge clk);
        #1;

        // Misalignment handling
        issue(1'b1, 32'h0, 4'hF, 32'h11111111, 32'h0, 1'b0);
        issue(1'b1, 32'h2, 4'hF, 32'hFFFFFFFF, 32'h0, MIS);
        issue(1'b0, 32'h0, 4'hF, 32'h0, (MIS ? 32'h11111111 : 32'hFFFFFFFF), 1'b0);
        issue(1'b1, 32'h2, 4'b1100, 32'hAABBCCDD, 32'h0, 1'b0);
        issue(1'b0, 32'h0, 4'hF, 32'h0, (MIS ? 32'hAABB1111 : 32'hAABBFFFF), 1'b0);
        issue(1'b0, 32'h0, 4'h0, 32'h0, (MIS ? 32'h0 : 32'hAABBFFFF), MIS);
        issue(1'b1, 32'h0, 4'b0101, 32'h55555555, 32'h0, MIS);
        issue(1'b0, 32'h0, 4'hF, 32'h0, (MIS ? 32'hAABB1111 : 32'hAA55FF55), 1'b0);
        go_idle();
        @(posedge clk);
        #1;

        // Reset during a read: the response must vanish
        issue(1'b1, 32'h20, 4'hF, 32'h77777777, 32'h0, 1'b0);
        req_we    = 1'b0;
        req_addr  = 32'h20;
        req_sel   = 4'hF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        #1;
        check("rst_kills_rsp", {31'b0, rsp_valid}, 32'h0);
        check("rst_busy_mid", {31'b0, busy}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Reset again at clear index 7, with a write held during the clear
        repeat (7) @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h24;
        req_sel   = 4'hF;
        req_wdata = 32'h99999999;
        @(negedge clk);
        rst = 1'b0;
        wait_clear("restart");
        go_idle();

        issue(1'b0, 32'h20, 4'hF, 32'h0, 32'h0, 1'b0);
        issue(1'b0, 32'h24, 4'hF, 32'h0, 32'h0, 1'b0);
        issue(1'b0, 32'h08, 4'hF, 32'h0, 32'h0, 1'b0);
        issue(1'b0, 32'h3C, 4'hF, 32'h0, 32'h0, 1'b0);
        go_idle();

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
